// File: rtl/sec_min_counter_pkg.sv
// Shared BCD constants and helpers for the seconds/minutes timebase.
package sec_min_counter_pkg;

    localparam logic [7:0] BCD_ZERO   = 8'h00;
    localparam logic [7:0] BCD_MAX_59 = 8'h59;
    localparam logic [7:0] BCD_M_CLR  = 8'h02;

    // Returns {wrap, next}; wrap is set when 59 rolls over to 00.
    function automatic logic [8:0] bcd_inc59(input logic [7:0] in);
        logic [8:0] r;
        if (in == BCD_MAX_59)
            r = {1'b1, BCD_ZERO};
        else if (in[3:0] >= 4'd9)
            r = {1'b0, in[7:4] + 4'd1, 4'h0};
        else
            r = {1'b0, in[7:4], in[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic bcd_valid59(input logic [7:0] in);
        return (in[7:4] <= 4'd5) && (in[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/sec_min_counter_cnt59.sv
// Packed-BCD 00..59 counter; load has priority over increment.
module bcd_cnt59
    import sec_min_counter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic [7:0] o_value,
    output logic       o_wrap
);

    logic [7:0] r_value;
    logic [8:0] w_nxt;

    assign w_nxt   = bcd_inc59(r_value);
    // Wrap is combinational so the next stage can advance in the same edge.
    assign o_wrap  = i_inc && !i_load && w_nxt[8];
    assign o_value = r_value;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_value <= BCD_ZERO;
        else if (i_load)
            r_value <= i_load_val;
        else if (i_inc)
            r_value <= w_nxt[7:0];
    end

endmodule

// File: rtl/sec_min_counter.sv
// Free-running 1 Hz prescaler with BCD seconds/minutes, minute flag and time-set load.
module sec_min_counter
    import sec_min_counter_pkg::*;
#(
    parameter int CLK_DIV = 50000000,
    parameter int CNT_W   = 26
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       set_en,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic [7:0] second,
    output logic [7:0] minute,
    output logic       m_bit,
    output logic       tick_1hz,
    output logic       hour_carry,
    output logic       set_err
);

    logic [CNT_W-1:0] r_presc;
    logic             r_m_bit, r_tick, r_hour_carry, r_set_err;
    logic             w_tick, w_set_ok, w_load, w_sec_inc, w_sec_wrap, w_min_wrap;
    logic [7:0]       w_sec, w_min;
    logic [8:0]       w_sec_nxt;

    assign w_tick    = en && (r_presc == CNT_W'(CLK_DIV - 1));
    assign w_set_ok  = bcd_valid59(set_min) && bcd_valid59(set_sec);
    assign w_load    = set_en && w_set_ok;
    // A valid load swallows a coincident tick; an invalid one does not.
    assign w_sec_inc = w_tick && !w_load;
    assign w_sec_nxt = bcd_inc59(w_sec);

    bcd_cnt59 u_sec (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_inc      (w_sec_inc),
        .i_load     (w_load),
        .i_load_val (set_sec),
        .o_value    (w_sec),
        .o_wrap     (w_sec_wrap)
    );

    bcd_cnt59 u_min (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_inc      (w_sec_wrap),
        .i_load     (w_load),
        .i_load_val (set_min),
        .o_value    (w_min),
        .o_wrap     (w_min_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_m_bit      <= 1'b0;
            r_tick       <= 1'b0;
            r_hour_carry <= 1'b0;
            r_set_err    <= 1'b0;
        end else begin
            r_tick       <= w_sec_inc;
            r_hour_carry <= w_min_wrap;
            r_set_err    <= set_en && !w_set_ok;
            if (w_load) begin
                r_presc <= '0;
                r_m_bit <= 1'b0;
            end else begin
                if (en)
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                // m_bit covers seconds 00 and 01 after a rollover.
                if (w_sec_wrap)
                    r_m_bit <= 1'b1;
                else if (w_sec_inc && w_sec_nxt[7:0] == BCD_M_CLR)
                    r_m_bit <= 1'b0;
            end
        end
    end

    assign second     = w_sec;
    assign minute     = w_min;
    assign m_bit      = r_m_bit;
    assign tick_1hz   = r_tick;
    assign hour_carry = r_hour_carry;
    assign set_err    = r_set_err;

endmodule

// File: tb/tb_sec_min_counter.sv
// Directed plus randomized bench; reference keeps time as plain integer seconds/minutes.
module tb_sec_min_counter;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, set_en = 1'b0;
    logic [7:0] set_min = 8'h00, set_sec = 8'h00;
    logic [7:0] second, minute;
    logic       m_bit, tick_1hz, hour_carry, set_err;

    int n_chk = 0, n_fail = 0;
    int m_pre = 0, m_sec = 0, m_min = 0;
    bit m_mbit = 0, e_tick = 0, e_hc = 0, e_err = 0;

    sec_min_counter #(.CLK_DIV(CLK_DIV), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .set_en(set_en),
        .set_min(set_min), .set_sec(set_sec),
        .second(second), .minute(minute), .m_bit(m_bit),
        .tick_1hz(tick_1hz), .hour_carry(hour_carry), .set_err(set_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_sec = 0; m_min = 0;
        m_mbit = 0; e_tick = 0; e_hc = 0; e_err = 0;
    endtask

    task automatic model_step(input bit ien, input bit iset, input logic [7:0] im, input logic [7:0] is);
        bit tick;
        tick   = ien && (m_pre == CLK_DIV - 1);
        e_tick = 0; e_hc = 0; e_err = 0;
        if (iset && bcd_ok(im) && bcd_ok(is)) begin
            m_sec = from_bcd(is); m_min = from_bcd(im); m_pre = 0; m_mbit = 0;
        end else begin
            if (iset) e_err = 1;
            if (ien) m_pre = (m_pre + 1) % CLK_DIV;
            if (tick) begin
                e_tick = 1;
                m_sec++;
                if (m_sec == 60) begin
                    m_sec = 0; m_mbit = 1; m_min++;
                    if (m_min == 60) begin m_min = 0; e_hc = 1; end
                end else if (m_sec == 2) begin
                    m_mbit = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".second"}, second, to_bcd(m_sec));
        check({tag, ".minute"}, minute, to_bcd(m_min));
        check({tag, ".m_bit"}, 8'(m_bit), 8'(m_mbit));
        check({tag, ".tick"}, 8'(tick_1hz), 8'(e_tick));
        check({tag, ".hour_carry"}, 8'(hour_carry), 8'(e_hc));
        check({tag, ".set_err"}, 8'(set_err), 8'(e_err));
    endtask

    task automatic cycle(input bit ien, input bit iset, input logic [7:0] im, input logic [7:0] is);
        en = ien; set_en = iset; set_min = im; set_sec = is;
        @(posedge clk); #1;
        model_step(ien, iset, im, is);
        check_all("cyc");
        set_en = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    // Advance until the next enabled edge is a tick edge.
    task automatic to_tick_edge();
        for (int i = 0; i < CLK_DIV && m_pre != CLK_DIV - 1; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // First tick lands on the fourth enabled edge after release
        run(3);
        check("pre_tick", 8'(tick_1hz), 8'h00);
        run(1);
        check("first_tick", 8'(tick_1hz), 8'h01);
        check("first_sec", second, 8'h01);

        cycle(1'b1, 1'b1, 8'h00, 8'h09);
        run(4);
        check("bcd_carry", second, 8'h10);

        cycle(1'b1, 1'b1, 8'h00, 8'h59);
        run(4);
        check("roll_sec", second, 8'h00);
        check("roll_min", minute, 8'h01);
        check("roll_mbit", 8'(m_bit), 8'h01);
        check("roll_hc", 8'(hour_carry), 8'h00);
        run(4);
        check("mbit_at01", 8'(m_bit), 8'h01);
        run(4);
        check("sec_at02", second, 8'h02);
        check("mbit_clr02", 8'(m_bit), 8'h00);

        cycle(1'b1, 1'b1, 8'h59, 8'h59);
        run(4);
        check("hwrap_min", minute, 8'h00);
        check("hwrap_hc", 8'(hour_carry), 8'h01);
        check("hwrap_mbit", 8'(m_bit), 8'h01);
        run(1);
        check("hc_one_cycle", 8'(hour_carry), 8'h00);

        cycle(1'b1, 1'b1, 8'h00, 8'h5A);
        check("bad_sec_err", 8'(set_err), 8'h01);
        cycle(1'b1, 1'b1, 8'h60, 8'h00);
        check("bad_min_err", 8'(set_err), 8'h01);
        check("bad_min_keep", minute, 8'h00);
        to_tick_edge();
        cycle(1'b1, 1'b1, 8'h60, 8'h00);
        check("bad_tick_err", 8'(set_err), 8'h01);
        check("bad_tick_tick", 8'(tick_1hz), 8'h01);

        to_tick_edge();
        cycle(1'b1, 1'b1, 8'h12, 8'h34);
        check("coll_sec", second, 8'h34);
        check("coll_tick", 8'(tick_1hz), 8'h00);
        run(3);
        check("coll_notick", 8'(tick_1hz), 8'h00);
        run(1);
        check("coll_next", second, 8'h35);

        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00);
        check("pause_sec", second, 8'h35);
        cycle(1'b0, 1'b1, 8'h07, 8'h08);
        check("load_while_off", second, 8'h08);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] rm, rs;
            bit         ren, rset;
            ren  = ($urandom_range(0, 3) != 0);
            rset = ($urandom_range(0, 15) == 0);
            rm   = ($urandom_range(0, 1) != 0) ? to_bcd($urandom_range(0, 59)) : 8'($urandom);
            rs   = ($urandom_range(0, 1) != 0) ? to_bcd($urandom_range(0, 59)) : 8'($urandom);
            cycle(ren, rset, rm, rs);
        end

        // Asynchronous reset mid-cycle
        cycle(1'b1, 1'b1, 8'h12, 8'h34);
        run(2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_sec", second, 8'h00);
        check("async_min", minute, 8'h00);
        check("async_mbit", 8'(m_bit), 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        run(4);
        check("after_rst_sec", second, 8'h01);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
